// File: rtl/variable_table_replicated.sv
// Truth-bit store for the 3-SAT solver: one coherent assignment served to CLUSTER_SIZE read channels,
// a single flip port that toggles a variable for every channel at once, and a zero/random init sweep.
module variable_table_replicated #(
    parameter int          VARIABLE_ADDRESS_WIDTH = 11,
    parameter int          NUM_VARIABLES          = 2048,
    parameter int          CLUSTER_SIZE           = 40,
    parameter int          FLIP_COUNT_WIDTH       = 32,
    parameter logic [31:0] LFSR_SEED              = 32'hACE12468
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            init_start_i,
    input  logic                                            init_mode_i,
    output logic                                            init_busy_o,
    output logic                                            init_done_o,
    input  logic [CLUSTER_SIZE-1:0]                         rd_en_i,
    input  logic [VARIABLE_ADDRESS_WIDTH*CLUSTER_SIZE-1:0]  rd_addr_i,
    output logic [CLUSTER_SIZE-1:0]                         rd_data_o,
    output logic [CLUSTER_SIZE-1:0]                         rd_valid_o,
    input  logic                                            flip_valid_i,
    input  logic [VARIABLE_ADDRESS_WIDTH-1:0]               flip_addr_i,
    output logic                                            flip_ready_o,
    output logic                                            flip_err_o,
    output logic [FLIP_COUNT_WIDTH-1:0]                     flip_count_o
);

    localparam int          W          = VARIABLE_ADDRESS_WIDTH;
    localparam logic [31:0] LfsrMask   = 32'h80200003;
    localparam logic [W:0]  NumVarsExt = (W+1)'(NUM_VARIABLES);
    localparam logic [W-1:0] LastAddr  = W'(NUM_VARIABLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_t;

    state_t                      state_q, state_d;
    logic [W-1:0]                sweepAddr_q, sweepAddr_d;
    logic                        mode_q, mode_d;
    logic [31:0]                 lfsr_q, lfsr_d;
    logic [FLIP_COUNT_WIDTH-1:0] flipCount_q, flipCount_d;
    logic                        initDone_q, initDone_d;
    logic                        flipErr_q, flipErr_d;
    logic [CLUSTER_SIZE-1:0]     rdData_q, rdData_d;
    logic [CLUSTER_SIZE-1:0]     rdValid_q, rdValid_d;

    // Every channel reads this single array, so all replicas see the same assignment by construction.
    logic [NUM_VARIABLES-1:0]    varTable_q;

    logic        inRun;
    logic        flipHandshake;
    logic        flipInRange;
    logic [31:0] lfsrNext;

    assign inRun         = (state_q == RUN);
    assign flipHandshake = flip_valid_i & inRun;
    assign flipInRange   = ({1'b0, flip_addr_i} < NumVarsExt);
    assign lfsrNext      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'h0);

    always_comb begin
        state_d     = state_q;
        sweepAddr_d = sweepAddr_q;
        mode_d      = mode_q;
        lfsr_d      = lfsr_q;
        flipCount_d = flipCount_q;
        initDone_d  = 1'b0;
        flipErr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_start_i) begin
                    state_d     = INIT;
                    sweepAddr_d = '0;
                    mode_d      = init_mode_i;
                    flipCount_d = '0;
                end
            end
            INIT: begin
                if (mode_q) begin
                    lfsr_d = lfsrNext;
                end
                if (sweepAddr_q == LastAddr) begin
                    state_d    = RUN;
                    initDone_d = 1'b1;
                end else begin
                    sweepAddr_d = sweepAddr_q + 1'b1;
                end
            end
            RUN: begin
                if (flipHandshake && !flipInRange) begin
                    flipErr_d = 1'b1;
                end
                // A restart request wins over a simultaneous flip for the counter only.
                if (init_start_i) begin
                    state_d     = INIT;
                    sweepAddr_d = '0;
                    mode_d      = init_mode_i;
                    flipCount_d = '0;
                end else if (flipHandshake && flipInRange && (flipCount_q != '1)) begin
                    flipCount_d = flipCount_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < CLUSTER_SIZE; g++) begin : gRead
        logic [W-1:0] addr;
        logic         inRange;
        assign addr         = rd_addr_i[g*W +: W];
        assign inRange      = ({1'b0, addr} < NumVarsExt);
        assign rdValid_d[g] = inRun & rd_en_i[g];
        assign rdData_d[g]  = !inRun      ? 1'b0 :
                              !rd_en_i[g] ? rdData_q[g] :
                              (inRange & varTable_q[addr]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sweepAddr_q <= '0;
            mode_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            flipCount_q <= '0;
            initDone_q  <= 1'b0;
            flipErr_q   <= 1'b0;
            rdData_q    <= '0;
            rdValid_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweepAddr_q <= sweepAddr_d;
            mode_q      <= mode_d;
            lfsr_q      <= lfsr_d;
            flipCount_q <= flipCount_d;
            initDone_q  <= initDone_d;
            flipErr_q   <= flipErr_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
        end
    end

    // Table contents carry no reset; reads sample the pre-edge value, giving read-before-write on flips.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            varTable_q[sweepAddr_q] <= mode_q & lfsr_q[0];
        end else if (flipHandshake && flipInRange) begin
            varTable_q[flip_addr_i] <= ~varTable_q[flip_addr_i];
        end
    end

    assign init_busy_o  = (state_q == INIT);
    assign init_done_o  = initDone_q;
    assign flip_ready_o = inRun;
    assign flip_err_o   = flipErr_q;
    assign flip_count_o = flipCount_q;
    assign rd_data_o    = rdData_q;
    assign rd_valid_o   = rdValid_q;

endmodule

// File: tb/tb_variable_table_replicated.sv
// Scoreboard bench: read expectations are queued per channel at the sampling edge and a monitor
// pops them on the falling edge; a second, small instance covers out-of-range flips and saturation.
module tb_variable_table_replicated;

    localparam int W  = 11;
    localparam int N  = 2048;
    localparam int CS = 40;
    localparam logic [31:0] Seed = 32'hACE12468;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            initStart, initMode, initBusy, initDone;
    logic [CS-1:0]   rdEn, rdData, rdValid;
    logic [W*CS-1:0] rdAddr;
    logic            flipValid, flipReady, flipErr;
    logic [W-1:0]    flipAddr;
    logic [31:0]     flipCount;

    logic            sInitStart, sInitMode, sInitBusy, sInitDone;
    logic [1:0]      sRdEn, sRdData, sRdValid;
    logic [2*W-1:0]  sRdAddr;
    logic            sFlipValid, sFlipReady, sFlipErr;
    logic [W-1:0]    sFlipAddr;
    logic [3:0]      sFlipCount;

    variable_table_replicated dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_start_i (initStart),
        .init_mode_i  (initMode),
        .init_busy_o  (initBusy),
        .init_done_o  (initDone),
        .rd_en_i      (rdEn),
        .rd_addr_i    (rdAddr),
        .rd_data_o    (rdData),
        .rd_valid_o   (rdValid),
        .flip_valid_i (flipValid),
        .flip_addr_i  (flipAddr),
        .flip_ready_o (flipReady),
        .flip_err_o   (flipErr),
        .flip_count_o (flipCount)
    );

    variable_table_replicated #(
        .VARIABLE_ADDRESS_WIDTH (11),
        .NUM_VARIABLES          (1000),
        .CLUSTER_SIZE           (2),
        .FLIP_COUNT_WIDTH       (4)
    ) dutSmall (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_start_i (sInitStart),
        .init_mode_i  (sInitMode),
        .init_busy_o  (sInitBusy),
        .init_done_o  (sInitDone),
        .rd_en_i      (sRdEn),
        .rd_addr_i    (sRdAddr),
        .rd_data_o    (sRdData),
        .rd_valid_o   (sRdValid),
        .flip_valid_i (sFlipValid),
        .flip_addr_i  (sFlipAddr),
        .flip_ready_o (sFlipReady),
        .flip_err_o   (sFlipErr),
        .flip_count_o (sFlipCount)
    );

    int          total = 0;
    int          bad   = 0;
    bit          modelTable [N];
    bit          firstRandom [N];
    logic [31:0] lfsrModel;
    bit          expQ [CS][$];
    bit          stageEn [CS];
    bit          stageVal [CS];

    function automatic logic [31:0] lfsrStep(logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One clock: inputs set beforehand are sampled at this edge, staged read expectations become due.
    task automatic applyStimulus();
        @(posedge clk);
        for (int ch = 0; ch < CS; ch++) begin
            if (stageEn[ch]) begin
                expQ[ch].push_back(stageVal[ch]);
                stageEn[ch] = 1'b0;
            end
        end
        #1;
        rdEn       = '0;
        flipValid  = 1'b0;
        initStart  = 1'b0;
        sRdEn      = '0;
        sFlipValid = 1'b0;
        sInitStart = 1'b0;
    endtask

    task automatic issueRead(int ch, int addr);
        rdEn[ch]           = 1'b1;
        rdAddr[ch*W +: W]  = W'(addr);
        stageEn[ch]        = 1'b1;
        stageVal[ch]       = modelTable[addr];
    endtask

    task automatic issueFlip(int addr);
        flipValid = 1'b1;
        flipAddr  = W'(addr);
        modelTable[addr] = ~modelTable[addr];
    endtask

    task automatic readAll();
        for (int base = 0; base < N; base += CS) begin
            for (int ch = 0; ch < CS; ch++) begin
                if (base + ch < N) issueRead(ch, base + ch);
            end
            applyStimulus();
        end
        applyStimulus();
        applyStimulus();
    endtask

    // Sweep with optional illegal traffic (reads, flips, a second init_start) while busy.
    task automatic runInit(bit mode, bit noisy);
        int n;
        initStart = 1'b1;
        initMode  = mode;
        applyStimulus();
        for (int a = 0; a < N; a++) begin
            if (mode) begin
                modelTable[a] = lfsrModel[0];
                lfsrModel     = lfsrStep(lfsrModel);
            end else begin
                modelTable[a] = 1'b0;
            end
        end
        n = 0;
        while (initBusy === 1'b1 && n < 3000) begin
            if (noisy) begin
                if (n % 512 == 0) checkOutput("flipReadyInInit", 64'(flipReady), 64'd0);
                rdEn           = '1;
                rdAddr[0 +: W] = W'(n);
                flipValid      = 1'b1;
                flipAddr       = W'(7);
                if (n == 100) begin
                    initStart = 1'b1;
                    initMode  = ~mode;
                end
            end
            n++;
            applyStimulus();
        end
        checkOutput("sweepLength", 64'(n), 64'(N));
        checkOutput("initDoneHigh", 64'(initDone), 64'd1);
        checkOutput("flipCountCleared", 64'(flipCount), 64'd0);
        applyStimulus();
        checkOutput("initDonePulse", 64'(initDone), 64'd0);
    endtask

    task automatic checkResetState(string tag);
        checkOutput({tag, "_busy"},   64'(initBusy),  64'd0);
        checkOutput({tag, "_done"},   64'(initDone),  64'd0);
        checkOutput({tag, "_rdData"}, 64'(rdData),    64'd0);
        checkOutput({tag, "_rdValid"},64'(rdValid),   64'd0);
        checkOutput({tag, "_ready"},  64'(flipReady), 64'd0);
        checkOutput({tag, "_err"},    64'(flipErr),   64'd0);
        checkOutput({tag, "_count"},  64'(flipCount), 64'd0);
    endtask

    // Monitor: every due expectation demands a valid response; any other valid is spurious.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < CS; ch++) begin
                if (expQ[ch].size() > 0) begin
                    e = expQ[ch].pop_front();
                    total++;
                    if (rdValid[ch] !== 1'b1 || rdData[ch] !== e) begin
                        bad++;
                        $display("[TB] FAIL read ch%0d: got valid=%b data=%b expected valid=1 data=%b",
                                 ch, rdValid[ch], rdData[ch], e);
                    end
                end else if (rdValid[ch] !== 1'b0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spuriousValid ch%0d: got valid=%b expected valid=0", ch, rdValid[ch]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int pending;
        bit held;
        rst_n      = 1'b0;
        initStart  = 1'b0;
        initMode   = 1'b0;
        rdEn       = '0;
        rdAddr     = '0;
        flipValid  = 1'b0;
        flipAddr   = '0;
        sInitStart = 1'b0;
        sInitMode  = 1'b0;
        sRdEn      = '0;
        sRdAddr    = '0;
        sFlipValid = 1'b0;
        sFlipAddr  = '0;
        for (int ch = 0; ch < CS; ch++) stageEn[ch] = 1'b0;
        lfsrModel = Seed;
        #1;
        checkResetState("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("idleBusy", 64'(initBusy), 64'd0);

        $display("[TB] zero init with traffic during the sweep");
        runInit(1'b0, 1'b1);
        readAll();

        $display("[TB] random init twice");
        runInit(1'b1, 1'b0);
        for (int a = 0; a < N; a++) firstRandom[a] = modelTable[a];
        readAll();
        runInit(1'b1, 1'b0);
        readAll();

        $display("[TB] flip ordering on address 5");
        issueRead(0, 5);
        issueFlip(5);
        applyStimulus();
        checkOutput("countAfterFlip5", 64'(flipCount), 64'd1);
        issueRead(1, 5);
        applyStimulus();
        held = modelTable[5];
        applyStimulus();
        applyStimulus();
        checkOutput("rdDataHold", 64'(rdData[1]), 64'(held));

        $display("[TB] double flip on address 2047");
        issueRead(2, 2047);
        issueFlip(2047);
        applyStimulus();
        issueRead(3, 2047);
        issueFlip(2047);
        applyStimulus();
        issueRead(4, 2047);
        applyStimulus();
        checkOutput("countAfter2047x2", 64'(flipCount), 64'd3);
        applyStimulus();
        applyStimulus();

        $display("[TB] reset in the middle of a sweep");
        initStart = 1'b1;
        initMode  = 1'b1;
        applyStimulus();
        repeat (700) applyStimulus();
        rst_n = 1'b0;
        #1;
        checkResetState("midReset");
        applyStimulus();
        applyStimulus();
        rst_n     = 1'b1;
        lfsrModel = Seed;
        applyStimulus();
        checkOutput("idleAfterReset", 64'(initBusy), 64'd0);
        runInit(1'b0, 1'b0);
        readAll();

        $display("[TB] small instance: out-of-range flip and counter saturation");
        sInitStart = 1'b1;
        applyStimulus();
        n = 0;
        while (sInitBusy === 1'b1 && n < 2000) begin
            n++;
            applyStimulus();
        end
        checkOutput("smallSweepLength", 64'(n), 64'd1000);
        sFlipValid = 1'b1;
        sFlipAddr  = W'(1500);
        applyStimulus();
        checkOutput("smallErrPulse", 64'(sFlipErr), 64'd1);
        checkOutput("smallCountOor", 64'(sFlipCount), 64'd0);
        sFlipValid = 1'b1;
        sFlipAddr  = W'(999);
        applyStimulus();
        checkOutput("smallErrClear", 64'(sFlipErr), 64'd0);
        checkOutput("smallCount999", 64'(sFlipCount), 64'd1);
        sRdEn            = 2'b11;
        sRdAddr[0 +: W]  = W'(999);
        sRdAddr[W +: W]  = W'(1500);
        applyStimulus();
        checkOutput("smallRdValid", 64'(sRdValid), 64'd3);
        checkOutput("smallRdData", 64'(sRdData), 64'd1);
        for (int k = 0; k < 19; k++) begin
            sFlipValid = 1'b1;
            sFlipAddr  = W'(3);
            applyStimulus();
        end
        checkOutput("smallCountSat", 64'(sFlipCount), 64'd15);

        pending = 0;
        for (int ch = 0; ch < CS; ch++) pending += expQ[ch].size();
        checkOutput("queueDrained", 64'(pending), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
